// File: rtl/serial_subtractor_8_if.sv
// Start/done handshake and operand/result bundle for the bit-serial subtractor.
// master: sequencing controller side; slave: subtractor side.
interface serial_subtractor_8_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             borrow;
    logic             overflow;

    modport master (
        output start, a, b,
        input  busy, done, diff, borrow, overflow
    );

    modport slave (
        input  start, a, b,
        output busy, done, diff, borrow, overflow
    );
endinterface

// File: rtl/serial_subtractor_8.sv
// Bit-serial two's-complement subtractor (a + ~b + 1), one full-adder cell reused LSB-first.
// Optional macro SUB_SAT_EN: saturate diff to signed min/max on overflow.
module serial_subtractor_8 #(
    parameter int WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    serial_subtractor_8_if.slave   bus
);
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-2:0] res_q, res_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             a_msb_q, a_msb_d;
    logic             b_msb_q, b_msb_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             borrow_q, borrow_d;
    logic             overflow_q, overflow_d;

    logic             fa_s;
    logic             fa_c;
    logic             nb;
    logic [WIDTH-1:0] raw_diff;
    logic             ovf;

    always_comb begin
        nb       = ~b_sh_q[0];
        fa_s     = a_sh_q[0] ^ nb ^ carry_q;
        fa_c     = (a_sh_q[0] & nb) | (a_sh_q[0] & carry_q) | (nb & carry_q);
        // Final sum bit joins the WIDTH-1 bits already shifted in.
        raw_diff = {fa_s, res_q};
        ovf      = (a_msb_q != b_msb_q) && (fa_s != a_msb_q);
    end

    always_comb begin
        state_d    = state_q;
        a_sh_d     = a_sh_q;
        b_sh_d     = b_sh_q;
        res_d      = res_q;
        cnt_d      = cnt_q;
        carry_d    = carry_q;
        a_msb_d    = a_msb_q;
        b_msb_d    = b_msb_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        diff_d     = diff_q;
        borrow_d   = borrow_q;
        overflow_d = overflow_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    a_sh_d  = bus.a;
                    b_sh_d  = bus.b;
                    a_msb_d = bus.a[WIDTH-1];
                    b_msb_d = bus.b[WIDTH-1];
                    carry_d = 1'b1;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                carry_d = fa_c;
                res_d   = raw_diff[WIDTH-1:1];
                a_sh_d  = a_sh_q >> 1;
                b_sh_d  = b_sh_q >> 1;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d    = DONE;
                    done_d     = 1'b1;
                    borrow_d   = ~fa_c;
                    overflow_d = ovf;
`ifdef SUB_SAT_EN
                    if (ovf)
                        diff_d = a_msb_q ? {1'b1, {(WIDTH-1){1'b0}}}
                                         : {1'b0, {(WIDTH-1){1'b1}}};
                    else
                        diff_d = raw_diff;
`else
                    diff_d = raw_diff;
`endif
                end
            end
            DONE: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            a_sh_q     <= '0;
            b_sh_q     <= '0;
            res_q      <= '0;
            cnt_q      <= '0;
            carry_q    <= 1'b0;
            a_msb_q    <= 1'b0;
            b_msb_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            diff_q     <= '0;
            borrow_q   <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            a_sh_q     <= a_sh_d;
            b_sh_q     <= b_sh_d;
            res_q      <= res_d;
            cnt_q      <= cnt_d;
            carry_q    <= carry_d;
            a_msb_q    <= a_msb_d;
            b_msb_q    <= b_msb_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            diff_q     <= diff_d;
            borrow_q   <= borrow_d;
            overflow_q <= overflow_d;
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.diff     = diff_q;
    assign bus.borrow   = borrow_q;
    assign bus.overflow = overflow_q;
endmodule

// File: tb/tb_serial_subtractor_8.sv
// Scoreboard bench for serial_subtractor_8 (WIDTH=8): expected results queued at start,
// checked when done pulses; also checks latency, busy length, ignored starts and reset abort.
module tb_serial_subtractor_8;
    logic clk = 1'b0;
    logic rst = 1'b1;

    serial_subtractor_8_if #(.WIDTH(8)) bus ();

    serial_subtractor_8 #(.WIDTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] d;
        logic       brw;
        logic       ovf;
    } exp_t;

    exp_t sb_q[$];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [7:0] a, input logic [7:0] b);
        exp_t e;
        logic [7:0] raw;
        raw   = a - b;
        e.a   = a;
        e.b   = b;
        e.brw = (a < b);
        e.ovf = (a[7] != b[7]) && (raw[7] != a[7]);
        e.d   = raw;
`ifdef SUB_SAT_EN
        if (e.ovf) e.d = a[7] ? 8'h80 : 8'h7F;
`endif
        return e;
    endfunction

    // Result monitor: pops the oldest expectation on every done pulse.
    always @(negedge clk) begin
        if (bus.done) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                $display("op a=%02h b=%02h -> diff=%02h borrow=%0b overflow=%0b (exp %02h %0b %0b)",
                         e.a, e.b, bus.diff, bus.borrow, bus.overflow, e.d, e.brw, e.ovf);
                chk("diff", {24'd0, bus.diff}, {24'd0, e.d});
                chk("borrow", {31'd0, bus.borrow}, {31'd0, e.brw});
                chk("overflow", {31'd0, bus.overflow}, {31'd0, e.ovf});
            end
        end
    end

    task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                          input bit inject, input bit do_rst);
        int done_k;
        int busy_n;
        int dones;
        done_k = -1;
        busy_n = 0;
        dones  = 0;
        @(negedge clk);
        bus.a     = a;
        bus.b     = b;
        bus.start = 1'b1;
        if (!do_rst) sb_q.push_back(model(a, b));
        @(negedge clk);
        bus.start = 1'b0;
        bus.a     = 8'($urandom);
        bus.b     = 8'($urandom);
        for (int k = 0; k < 14; k++) begin
            if (k > 0) @(negedge clk);
            if (bus.busy) busy_n++;
            if (bus.done) begin
                dones++;
                done_k = k;
            end
            if (do_rst && k == 4) begin
                chk("rst_busy", {31'd0, bus.busy}, 32'd0);
                chk("rst_done", {31'd0, bus.done}, 32'd0);
                chk("rst_diff", {24'd0, bus.diff}, 32'd0);
                rst = 1'b0;
            end
            if (do_rst && k == 3) rst = 1'b1;
            if (inject && (k == 2 || k == 8)) begin
                bus.start = 1'b1;
                bus.a     = 8'hAA;
                bus.b     = 8'h55;
            end
            if (inject && (k == 3 || k == 9)) bus.start = 1'b0;
        end
        if (do_rst) begin
            chk("rst_no_done", dones, 0);
            chk("rst_busy_cycles", busy_n, 4);
        end else begin
            chk("latency", done_k, 8);
            chk("busy_cycles", busy_n, 9);
            chk("done_pulses", dones, 1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

    initial begin
        bus.start = 1'b0;
        bus.a     = 8'h00;
        bus.b     = 8'h00;
        rst       = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_busy", {31'd0, bus.busy}, 32'd0);
        chk("reset_done", {31'd0, bus.done}, 32'd0);
        chk("reset_diff", {24'd0, bus.diff}, 32'd0);
        chk("reset_borrow", {31'd0, bus.borrow}, 32'd0);
        chk("reset_overflow", {31'd0, bus.overflow}, 32'd0);
        rst = 1'b0;

        run_op(8'h05, 8'h03, 1'b0, 1'b0);
        run_op(8'h00, 8'h01, 1'b0, 1'b0);
        run_op(8'h80, 8'h01, 1'b0, 1'b0);
        run_op(8'h7F, 8'hFF, 1'b0, 1'b0);
        run_op(8'h10, 8'h01, 1'b1, 1'b0);
        run_op(8'h3C, 8'h21, 1'b0, 1'b1);
        run_op(8'h42, 8'h99, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            run_op(8'($urandom), 8'($urandom), 1'b0, 1'b0);
        end
        run_op(8'hFF, 8'hFF, 1'b0, 1'b0);
        run_op(8'h00, 8'h80, 1'b0, 1'b0);

        chk("scoreboard_empty", sb_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
